// File: rtl/plic_mt.sv
// Multi-target platform-level interrupt controller: gateways, pending array,
// per-target registered arbiter, claim/complete and nesting stack.
// Optional feature macro: PLIC_EDGE_TRIG_EN adds src_edge and edge-mode gateways.
module plic_mt #(
  parameter int NUM_SRC    = 31,
  parameter int NUM_TGT    = 2,
  parameter int PRIO_WIDTH = 3,
  parameter int NEST_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC:0]                    src_irq,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic [NUM_SRC:0]                    src_edge,
`endif
  input  logic [PRIO_WIDTH*(NUM_SRC+1)-1:0]   prio_1d,
  input  logic [NUM_TGT*(NUM_SRC+1)-1:0]      ie_1d,
  input  logic [NUM_TGT*PRIO_WIDTH-1:0]       thresh_1d,
  input  logic [NUM_TGT-1:0]                  claim_req,
  output logic [NUM_TGT-1:0]                  claim_vld,
  output logic [8*NUM_TGT-1:0]                claim_id,
  input  logic [NUM_TGT-1:0]                  cmplt_req,
  input  logic [8*NUM_TGT-1:0]                cmplt_id,
  output logic [NUM_SRC:0]                    ip,
  output logic [NUM_TGT-1:0]                  irq
);

  localparam int S  = NUM_SRC + 1;
  localparam int CW = $clog2(NEST_DEPTH + 1);

  typedef logic [PRIO_WIDTH-1:0] prio_t;

  // Source 0 is reserved and can never pend.
  localparam logic [S-1:0] SRC_MASK = {{NUM_SRC{1'b1}}, 1'b0};

  logic [S-1:0]    ip_q;
  logic [S-1:0]    closed_q;
  logic [S-1:0]    req;
  logic [S-1:0]    take;
  logic [S-1:0]    reopen;
  logic [S-1:0]    claim_clr;
  logic [S-1:0]    cmplt_hit;
  prio_t           src_prio [S];
  prio_t           thresh   [NUM_TGT];

  prio_t           best_prio_p0 [NUM_TGT];
  logic [7:0]      best_id_p0   [NUM_TGT];
  logic [7:0]      best_id_p1   [NUM_TGT];

  prio_t           stk     [NUM_TGT][NEST_DEPTH];
  logic [CW-1:0]   cnt     [NUM_TGT];
  logic [CW-1:0]   cnt_pop [NUM_TGT];
  prio_t           top     [NUM_TGT];
  logic [NUM_TGT-1:0] full;

  logic [NUM_TGT-1:0] grant;
  prio_t           gprio [NUM_TGT];

  assign ip = ip_q;

  always_comb begin
    for (int i = 0; i < S; i++) src_prio[i] = prio_1d[i*PRIO_WIDTH +: PRIO_WIDTH];
    for (int t = 0; t < NUM_TGT; t++) thresh[t] = thresh_1d[t*PRIO_WIDTH +: PRIO_WIDTH];
  end

  // Gateway request: level, or rising edge plus a single held-over edge.
`ifdef PLIC_EDGE_TRIG_EN
  logic [S-1:0] hist_q;
  logic [S-1:0] edge_pend_q;
  logic [S-1:0] rise;

  assign rise = src_irq & ~hist_q;
  assign req  = (src_edge & rise) | (~src_edge & src_irq) | edge_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q      <= '0;
      edge_pend_q <= '0;
    end else begin
      hist_q      <= src_irq;
      edge_pend_q <= (closed_q & (edge_pend_q | (src_edge & rise))) & SRC_MASK;
    end
  end
`else
  assign req = src_irq;
`endif

  // A complete only reopens a closed gateway; that cycle's request is ignored.
  always_comb begin
    claim_clr = '0;
    cmplt_hit = '0;
    for (int i = 1; i < S; i++) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        if (grant[t] && best_id_p1[t] == 8'(i)) claim_clr[i] = 1'b1;
        if (cmplt_req[t] && cmplt_id[t*8 +: 8] == 8'(i)) cmplt_hit[i] = 1'b1;
      end
    end
  end

  assign reopen = closed_q & cmplt_hit;
  assign take   = ~closed_q & req & SRC_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_q     <= '0;
      closed_q <= '0;
    end else begin
      ip_q     <= (ip_q & ~claim_clr) | take;
      closed_q <= (closed_q & ~reopen) | take;
    end
  end

  // Stage p0: combinational winner per target, lowest id wins ties.
  always_comb begin
    for (int t = 0; t < NUM_TGT; t++) begin
      best_prio_p0[t] = '0;
      best_id_p0[t]   = '0;
      for (int i = NUM_SRC; i >= 0; i--) begin
        if (ip_q[i] && ie_1d[t*S + i] && src_prio[i] != '0 &&
            src_prio[i] >= best_prio_p0[t]) begin
          best_prio_p0[t] = src_prio[i];
          best_id_p0[t]   = 8'(i);
        end
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_TGT; t++) begin
      top[t]  = '0;
      full[t] = (int'(cnt[t]) == NEST_DEPTH);
      for (int d = 0; d < NEST_DEPTH; d++)
        if (int'(cnt[t]) == d + 1) top[t] = stk[t][d];
      cnt_pop[t] = cnt[t] - CW'(cmplt_req[t] && cnt[t] != '0);
    end
  end

  // Claim arbitration; a pop in the same cycle frees a slot for the push.
  always_comb begin
    logic [NUM_TGT-1:0] g;
    logic               ipb;
    g = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      gprio[t] = '0;
      ipb      = 1'b0;
      for (int i = 0; i < S; i++) begin
        if (best_id_p1[t] == 8'(i)) begin
          gprio[t] = src_prio[i];
          ipb      = ip_q[i];
        end
      end
      g[t] = claim_req[t] && best_id_p1[t] != '0 && ipb && !(full[t] && !cmplt_req[t]);
      for (int u = 0; u < t; u++)
        if (g[u] && best_id_p1[u] == best_id_p1[t]) g[t] = 1'b0;
    end
    grant = g;
  end

  // Stage p1: registered winner, interrupt line and claim response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq       <= '0;
      claim_vld <= '0;
      claim_id  <= '0;
      for (int t = 0; t < NUM_TGT; t++) begin
        best_id_p1[t] <= '0;
        cnt[t]        <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TGT; t++) begin
        best_id_p1[t]      <= best_id_p0[t];
        irq[t]             <= (best_prio_p0[t] > thresh[t]) && (best_prio_p0[t] > top[t]) && !full[t];
        claim_vld[t]       <= claim_req[t];
        claim_id[t*8 +: 8] <= grant[t] ? best_id_p1[t] : 8'd0;
        cnt[t]             <= cnt_pop[t] + CW'(grant[t]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_TGT; t++)
      for (int d = 0; d < NEST_DEPTH; d++)
        if (grant[t] && int'(cnt_pop[t]) == d) stk[t][d] <= gprio[t];
  end

endmodule

// File: tb/tb_plic_mt.sv
// Self-checking bench for plic_mt: directed vectors, a cycle-level reference
// model checked every cycle, and hand-computed literal expectations.
module tb_plic_mt;
  localparam int NUM_SRC = 31;
  localparam int NUM_TGT = 2;
  localparam int PW      = 3;
  localparam int ND      = 2;
  localparam int S       = NUM_SRC + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [S-1:0]          src_irq   = '0;
`ifdef PLIC_EDGE_TRIG_EN
  logic [S-1:0]          src_edge  = '0;
`endif
  logic [PW*S-1:0]       prio_1d   = '0;
  logic [NUM_TGT*S-1:0]  ie_1d     = '0;
  logic [NUM_TGT*PW-1:0] thresh_1d = '0;
  logic [NUM_TGT-1:0]    claim_req = '0;
  logic [NUM_TGT-1:0]    claim_vld;
  logic [8*NUM_TGT-1:0]  claim_id;
  logic [NUM_TGT-1:0]    cmplt_req = '0;
  logic [8*NUM_TGT-1:0]  cmplt_id  = '0;
  logic [S-1:0]          ip;
  logic [NUM_TGT-1:0]    irq;

  always #5 clk = ~clk;

  plic_mt #(.NUM_SRC(NUM_SRC), .NUM_TGT(NUM_TGT), .PRIO_WIDTH(PW), .NEST_DEPTH(ND)) dut (
    .clk(clk), .rst(rst), .src_irq(src_irq),
`ifdef PLIC_EDGE_TRIG_EN
    .src_edge(src_edge),
`endif
    .prio_1d(prio_1d), .ie_1d(ie_1d), .thresh_1d(thresh_1d),
    .claim_req(claim_req), .claim_vld(claim_vld), .claim_id(claim_id),
    .cmplt_req(cmplt_req), .cmplt_id(cmplt_id), .ip(ip), .irq(irq)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  logic [S-1:0]       m_ip, m_closed;
`ifdef PLIC_EDGE_TRIG_EN
  logic [S-1:0]       m_epend, m_hist;
`endif
  int                 m_best_id [NUM_TGT];
  logic [NUM_TGT-1:0] m_irq, m_cvld;
  logic [7:0]         m_cid [NUM_TGT];
  int                 m_stk [NUM_TGT][$];

  function automatic int prio_of(int i);
    return int'(prio_1d[i*PW +: PW]);
  endfunction

  function automatic int thr_of(int t);
    return int'(thresh_1d[t*PW +: PW]);
  endfunction

  task automatic model_reset();
    m_ip = '0;
    m_closed = '0;
`ifdef PLIC_EDGE_TRIG_EN
    m_epend = '0;
    m_hist = '0;
`endif
    m_irq = '0;
    m_cvld = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      m_best_id[t] = 0;
      m_cid[t] = '0;
      m_stk[t].delete();
    end
  endtask

  task automatic model_step();
    int bp [NUM_TGT];
    int bid [NUM_TGT];
    bit g [NUM_TGT];
    int gp [NUM_TGT];
    bit taken [S];
    logic [S-1:0] clr, nip, ncl;
`ifdef PLIC_EDGE_TRIG_EN
    logic [S-1:0] nep;
`endif
    for (int i = 0; i < S; i++) taken[i] = 1'b0;
    clr = '0;
    // Highest priority eligible source; strict compare in ascending order keeps the lowest id on ties.
    for (int t = 0; t < NUM_TGT; t++) begin
      int top;
      bp[t] = 0;
      bid[t] = 0;
      for (int i = 1; i <= NUM_SRC; i++)
        if (m_ip[i] && ie_1d[t*S + i] && prio_of(i) > bp[t]) begin
          bp[t] = prio_of(i);
          bid[t] = i;
        end
      top = (m_stk[t].size() > 0) ? m_stk[t][$] : 0;
      m_irq[t] = (bp[t] > thr_of(t)) && (bp[t] > top) && (m_stk[t].size() < ND);
    end
    for (int t = 0; t < NUM_TGT; t++) begin
      int id;
      id = m_best_id[t];
      g[t] = claim_req[t] && id != 0 && m_ip[id] &&
             !(m_stk[t].size() == ND && !cmplt_req[t]) && !taken[id];
      gp[t] = 0;
      if (g[t]) begin
        taken[id] = 1'b1;
        clr[id] = 1'b1;
        gp[t] = prio_of(id);
      end
      m_cvld[t] = claim_req[t];
      m_cid[t] = g[t] ? 8'(id) : 8'd0;
    end
    for (int t = 0; t < NUM_TGT; t++) begin
      if (cmplt_req[t] && m_stk[t].size() > 0) void'(m_stk[t].pop_back());
      if (g[t]) m_stk[t].push_back(gp[t]);
    end
    nip = m_ip & ~clr;
    ncl = m_closed;
`ifdef PLIC_EDGE_TRIG_EN
    nep = m_epend;
`endif
    for (int i = 1; i <= NUM_SRC; i++) begin
      bit hit;
      hit = 1'b0;
      for (int t = 0; t < NUM_TGT; t++)
        if (cmplt_req[t] && int'(cmplt_id[t*8 +: 8]) == i) hit = 1'b1;
`ifdef PLIC_EDGE_TRIG_EN
      begin
        bit rise, r;
        rise = src_irq[i] && !m_hist[i];
        r = src_edge[i] ? rise : src_irq[i];
        if (m_closed[i]) begin
          if (hit) ncl[i] = 1'b0;
          if (src_edge[i] && rise) nep[i] = 1'b1;
        end else begin
          if (r || m_epend[i]) begin
            nip[i] = 1'b1;
            ncl[i] = 1'b1;
          end
          nep[i] = 1'b0;
        end
      end
`else
      if (m_closed[i]) begin
        if (hit) ncl[i] = 1'b0;
      end else if (src_irq[i]) begin
        nip[i] = 1'b1;
        ncl[i] = 1'b1;
      end
`endif
    end
    m_ip = nip;
    m_closed = ncl;
`ifdef PLIC_EDGE_TRIG_EN
    m_epend = nep;
    m_hist = src_irq;
`endif
    for (int t = 0; t < NUM_TGT; t++) m_best_id[t] = bid[t];
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic [8*NUM_TGT-1:0] ecid;
        for (int t = 0; t < NUM_TGT; t++) ecid[t*8 +: 8] = m_cid[t];
        chk("model ip", 64'(ip), 64'(m_ip));
        chk("model irq", 64'(irq), 64'(m_irq));
        chk("model claim_vld", 64'(claim_vld), 64'(m_cvld));
        chk("model claim_id", 64'(claim_id), 64'(ecid));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    src_irq = '0;
`ifdef PLIC_EDGE_TRIG_EN
    src_edge = '0;
`endif
    prio_1d = '0;
    ie_1d = '0;
    thresh_1d = '0;
    claim_req = '0;
    cmplt_req = '0;
    cmplt_id = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_prio(input int i, input int p);
    prio_1d[i*PW +: PW] = PW'(p);
  endtask

  task automatic set_ie(input int t, input int i);
    ie_1d[t*S + i] = 1'b1;
  endtask

  task automatic do_claim(input int t, input int exp, input string nm);
    claim_req[t] = 1'b1;
    @(negedge clk);
    claim_req[t] = 1'b0;
    chk({nm, " vld"}, 64'(claim_vld[t]), 64'd1);
    chk(nm, 64'(claim_id[t*8 +: 8]), 64'(exp));
  endtask

  task automatic do_cmplt(input int t, input int id);
    cmplt_req[t] = 1'b1;
    cmplt_id[t*8 +: 8] = 8'(id);
    @(negedge clk);
    cmplt_req[t] = 1'b0;
    cmplt_id = '0;
  endtask

  initial begin
    wait_cyc(2);
    rst = 1'b0;
    chk("reset ip", 64'(ip), 64'd0);
    chk("reset irq", 64'(irq), 64'd0);
    chk("reset claim_vld", 64'(claim_vld), 64'd0);

    // Level claim/complete
    do_reset();
    set_prio(5, 3);
    set_ie(0, 5);
    src_irq[5] = 1'b1;
    wait_cyc(1);
    chk("lvl ip after 1", 64'(ip[5]), 64'd1);
    chk("lvl irq after 1", 64'(irq[0]), 64'd0);
    wait_cyc(1);
    chk("lvl irq after 2", 64'(irq[0]), 64'd1);
    do_claim(0, 5, "lvl claim");
    chk("lvl ip cleared", 64'(ip[5]), 64'd0);
    wait_cyc(3);
    chk("lvl no repend", 64'(ip[5]), 64'd0);
    do_cmplt(0, 5);
    chk("lvl ip at reopen", 64'(ip[5]), 64'd0);
    wait_cyc(1);
    chk("lvl ip repend", 64'(ip[5]), 64'd1);
    wait_cyc(1);
    do_claim(0, 5, "b2b first");
    do_claim(0, 0, "b2b second");

    // Tie and priority
    do_reset();
    set_prio(3, 2);
    set_prio(7, 2);
    set_ie(0, 3);
    set_ie(0, 7);
    src_irq[3] = 1'b1;
    src_irq[7] = 1'b1;
    wait_cyc(2);
    do_claim(0, 3, "tie claim");
    wait_cyc(2);
    chk("tie equal prio masked", 64'(irq[0]), 64'd0);
    set_prio(7, 4);
    wait_cyc(1);
    chk("prio raise irq", 64'(irq[0]), 64'd1);
    do_claim(0, 7, "prio raise claim");
    do_cmplt(0, 7);
    do_cmplt(0, 3);
    wait_cyc(3);

    // Threshold boundary
    do_reset();
    set_prio(12, 3);
    set_ie(0, 12);
    thresh_1d[PW-1:0] = 3'd3;
    src_irq[12] = 1'b1;
    wait_cyc(3);
    chk("thresh equal", 64'(irq[0]), 64'd0);
    thresh_1d[PW-1:0] = 3'd2;
    wait_cyc(1);
    chk("thresh below", 64'(irq[0]), 64'd1);

    // Priority 0 never interrupts
    do_reset();
    set_ie(0, 10);
    src_irq[10] = 1'b1;
    wait_cyc(3);
    chk("prio0 ip", 64'(ip[10]), 64'd1);
    chk("prio0 irq", 64'(irq[0]), 64'd0);
    do_claim(0, 0, "prio0 claim");

    // Nesting with depth 2
    do_reset();
    set_prio(2, 2);
    set_prio(6, 5);
    set_prio(11, 4);
    set_ie(0, 2);
    set_ie(0, 6);
    set_ie(0, 11);
    src_irq[2] = 1'b1;
    wait_cyc(2);
    do_claim(0, 2, "nest first");
    src_irq[6] = 1'b1;
    wait_cyc(2);
    chk("nest preempt irq", 64'(irq[0]), 64'd1);
    do_claim(0, 6, "nest preempt claim");
    src_irq[11] = 1'b1;
    wait_cyc(3);
    chk("nest full irq", 64'(irq[0]), 64'd0);
    do_claim(0, 0, "nest full claim");
    do_cmplt(0, 6);
    chk("nest irq at pop", 64'(irq[0]), 64'd0);
    wait_cyc(1);
    chk("nest irq after pop", 64'(irq[0]), 64'd1);

    // Dual-target race
    do_reset();
    set_prio(9, 3);
    set_ie(0, 9);
    set_ie(1, 9);
    src_irq[9] = 1'b1;
    wait_cyc(2);
    claim_req = 2'b11;
    @(negedge clk);
    claim_req = 2'b00;
    chk("race t0 id", 64'(claim_id[7:0]), 64'd9);
    chk("race t1 id", 64'(claim_id[15:8]), 64'd0);
    chk("race vld", 64'(claim_vld), 64'd3);

`ifdef PLIC_EDGE_TRIG_EN
    // Edge mode
    do_reset();
    src_edge[4] = 1'b1;
    set_prio(4, 3);
    set_ie(0, 4);
    src_irq[4] = 1'b1;
    @(negedge clk);
    src_irq[4] = 1'b0;
    chk("edge ip", 64'(ip[4]), 64'd1);
    wait_cyc(1);
    src_irq[4] = 1'b1;
    @(negedge clk);
    src_irq[4] = 1'b0;
    wait_cyc(1);
    do_claim(0, 4, "edge claim");
    src_irq[4] = 1'b1;
    @(negedge clk);
    src_irq[4] = 1'b0;
    wait_cyc(2);
    chk("edge closed", 64'(ip[4]), 64'd0);
    do_cmplt(0, 4);
    wait_cyc(1);
    chk("edge pend repend", 64'(ip[4]), 64'd1);
    wait_cyc(1);
    do_claim(0, 4, "edge second claim");
    do_cmplt(0, 4);
    wait_cyc(3);
    chk("edge third lost", 64'(ip[4]), 64'd0);
`endif

    // Asynchronous reset mid-claim
    do_reset();
    set_prio(9, 3);
    set_ie(0, 9);
    src_irq[9] = 1'b1;
    wait_cyc(2);
    claim_req[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("pre-reset claim id", 64'(claim_id[7:0]), 64'd9);
    #1;
    rst = 1'b1;
    #1;
    chk("async claim_vld", 64'(claim_vld), 64'd0);
    chk("async claim_id", 64'(claim_id), 64'd0);
    chk("async irq", 64'(irq), 64'd0);
    chk("async ip", 64'(ip), 64'd0);
    claim_req = '0;
    set_prio(9, 1);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(3);
    chk("stack empty after reset", 64'(irq[0]), 64'd1);

    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/plic_mt.md
# plic_mt

Multi-target, parametrised successor to the single-target platform-level interrupt controller in the `int_top` hierarchy. It contains the following:
- per-source gateways, with optional edge-triggered mode;
- the pending array;
- one registered priority arbiter per target (hart context);
- a claim/complete handshake per target;
- a per-target priority stack for nested preemption.

Its outputs feed one interrupt-control block per target.

## Interface
Parameters:
- `NUM_SRC`, 31: highest source id. Source 0 is reserved and never pends. Range 1..255.
- `NUM_TGT`, 2: number of targets (contexts).
- `PRIO_WIDTH`, 3: priority width. Priority 0 means never interrupt.
- `NEST_DEPTH`, 4: per-target nesting stack depth, at least 1.

Ports (S = `NUM_SRC`+1):
- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: reset, asynchronous, active-high.
- `src_irq`  in  S: raw source requests. Bit 0 is ignored.
- `src_edge`  in  S: 1 selects edge mode for that source. Present only with `PLIC_EDGE_TRIG_EN`.
- `prio_1d`  in  PRIO_WIDTH*S: source priorities. Source i occupies `[i*PRIO_WIDTH +: PRIO_WIDTH]`.
- `ie_1d`  in  NUM_TGT*S: enables. Target t occupies `[t*S +: S]`.
- `thresh_1d`  in  NUM_TGT*PRIO_WIDTH: per-target thresholds.
- `claim_req`  in  NUM_TGT: one-cycle claim strobe per target.
- `claim_vld`  out  NUM_TGT: one-cycle response strobe.
- `claim_id`  out  8*NUM_TGT: claimed id, valid while `claim_vld`. Value 0 means no interrupt.
- `cmplt_req`  in  NUM_TGT: one-cycle complete strobe.
- `cmplt_id`  in  8*NUM_TGT: id being completed.
- `ip`  out  S: pending bits.
- `irq`  out  NUM_TGT: per-target external interrupt, registered.

## Operation
- **Gateway.** Each source has a gateway in one of two states, OPEN or CLOSED.
  - OPEN with a request seen: set `ip[i]` and go to CLOSED.
  - CLOSED: further requests do not pend.
  - CLOSED goes to OPEN on any `cmplt_req[t]` with `cmplt_id[t]==i`. A complete for an OPEN gateway, or for id 0 or an id above `NUM_SRC`, is ignored.
- **Request, level mode.** The request is `src_irq[i]` high.
- **Request, edge mode (macro only).** The request is a rising edge of `src_irq[i]`.
  - An edge arriving while CLOSED sets a one-bit `edge_pend[i]`.
  - On reopen, `edge_pend` is forwarded as a request and cleared.
  - Further edges while `edge_pend` is set are lost.
- **Arbiter, per target t.**
  - Eligible: `ip[i] & ie[t][i]` and `prio[i]!=0`.
  - Winner: the eligible source with the highest priority; ties go to the lowest id.
  - Registered as `best_id[t]` / `best_prio[t]`. Both are 0 if nothing is eligible.
- **Interrupt.** `irq[t]` is registered as: `best_prio[t] > thresh[t]` AND `best_prio[t] > top[t]` AND stack not full.
  - `top[t]` is the stack-top priority, or 0 if the stack is empty.
- **Claim.** On `claim_req[t]`, the next edge registers `claim_vld[t]=1` and a `claim_id[t]`:
  - `claim_id[t]` is `best_id[t]` if that is nonzero, `ip[best_id]` is still set, and no lower-index target claims the same id in the same cycle.
  - Otherwise `claim_id[t]` is 0.
  - On a nonzero claim, `ip[id]` clears and `prio[id]` is pushed on target t's stack.
  - A claim made while the stack is full returns 0 and pushes nothing.
- **Complete.** On `cmplt_req[t]`, target t's stack is popped if non-empty. The pop happens independently of the gateway update.
- **Simultaneous claim and complete, same target, same cycle.** The pop is applied first, then the push.
- **Complete and request on the same source, same cycle.** The gateway reopens; the request is sampled from the next cycle on.

## Timing
- Reset values: `ip`=0, every gateway OPEN, `edge_pend`=0, edge-detect history=0, `best_*`=0, `irq`=0, `claim_vld`=0, `claim_id`=0, every stack empty.
- `src_irq` sampled high at edge N gives `ip` at N+1, `best`/`irq` at N+2.
- `claim_req` at edge N gives `claim_vld`/`claim_id` at N+1, with `ip` cleared at N+1. `best`/`irq` reflect the claim at N+2.
- A back-to-back claim at N+1 sees a stale `best` and therefore returns 0.
- Changes to `ie`, `prio` or `thresh` appear on `irq` 1 cycle later.
- Asserting reset mid-handshake drops the response and empties the stacks immediately (asynchronous).

## Configuration
- `PLIC_EDGE_TRIG_EN` defined: the `src_edge` port, the edge detectors and the `edge_pend` bits exist.
- Not defined: the port is absent and every source is level-triggered.

## Test plan
- **Level claim/complete.** Setup: reset, `prio[5]=3`, `ie[0][5]=1`, `thresh[0]=0`. Raise `src_irq[5]`. Required:
  - `ip[5]` after 1 cycle, `irq[0]` after 2.
  - Claim returns 5, `ip[5]` clears, and it does not re-pend while `src_irq[5]` is held.
  - After complete 5, `ip[5]` re-sets next cycle.
- **Tie and priority.**
  - Sources 3 and 7 at prio 2: claim returns 3.
  - Raise `prio[7]` to 4: claim returns 7.
  - Source with `prio` 0: never pends to `irq`.
- **Nesting.** `NEST_DEPTH`=2, claim prio-2 id, then prio-5 pending:
  - `irq` stays high and the claim returns it.
  - Then a prio-4 pending source: `irq` stays low until complete.
  - A third claim while the stack is full returns 0.
- **Dual-target race.** Both targets enable source 9 and claim in the same cycle: target 0 gets 9, target 1 gets 0.
- **Edge mode (macro).** Two pulses on source 4, the second while CLOSED:
  - One claim returns 4.
  - After complete, `ip[4]` re-sets from `edge_pend`.
  - A third edge during CLOSED with `edge_pend` already set is lost.
- **Async reset.** Assert `rst` mid-claim: all outputs 0 immediately and every stack empty.
